stopwatch_counter: RTL
======================

Name: stopwatch_counter

Overview:
- Downstream consumer of the centisecond divider output: converts each rising edge of the centisecond clock into one centisecond count.
- Maintains a BCD stopwatch value MM:SS.CC with start/stop/clear control.
- Drives the six-digit display/mux stage.
- Whole block runs on clk; centisecond_clock is treated as a data input, synchronized and edge-detected, never used as a clock.

Parameters:
- MIN_LIMIT, 99, highest minute value (1..99) before wrap to 00:00.00.
- SYNC_STAGES, 2, synchronizer flops on centisecond_clock before edge detect (min 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- centisecond_clock  input  1  divider output; one rising edge = 1 centisecond
- start_stop  input  1  debounced button level; rising edge toggles run/pause
- clear  input  1  debounced button level; rising edge zeroes count
- lap  input  1  debounced button level; rising edge toggles display hold (LAP_HOLD_EN only)
- cs_ones, cs_tens  output  4 each  centisecond BCD digits
- sec_ones, sec_tens  output  4 each  seconds BCD (sec_tens 0..5)
- min_ones, min_tens  output  4 each  minutes BCD
- running  output  1  high in RUN state
- overflow  output  1  sticky wrap indicator
- lap_held  output  1  display frozen (LAP_HOLD_EN only; else constant 0)

Behaviour:
- Reset: all digits 0, running 0, overflow 0, lap_held 0, state IDLE, synchronizer and edge registers 0. Reset overrides every other input.
- Tick detect:
  - centisecond_clock passes through SYNC_STAGES flops plus one delay flop.
  - tick = last sync stage high AND delay flop low.
  - With SYNC_STAGES=2, digits update on the 3rd clk rising edge after the first edge that samples centisecond_clock high.
  - Exactly one increment per input rising edge. Falling edges are ignored.
- Buttons: each of start_stop, clear, lap is registered and rising-edge detected internally. Holding a level high acts once.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: count 00:00.00. start_stop edge goes to RUN.
  - RUN: ticks increment. start_stop edge goes to PAUSE. clear edge zeroes count and stays in RUN.
  - PAUSE: ticks ignored. start_stop edge goes to RUN. clear edge zeroes count and goes to IDLE.
- Increment chain (one tick):
  - cs_ones 9 to 0 with carry to cs_tens.
  - cs_tens 9 to 0 with carry to sec_ones.
  - sec_ones 9 to 0 with carry to sec_tens.
  - sec_tens 5 to 0 with carry to minutes.
  - Minutes increment in BCD.
  - At MIN_LIMIT:59.99 the next tick gives 00:00.00 and sets overflow. Counting continues.
- overflow clears only on a clear edge or reset.
- Digits never hold non-BCD values; sec_tens never exceeds 5.
- Simultaneous events:
  - clear and tick in the same cycle: clear wins, result 00:00.00.
  - clear and start_stop in the same cycle: clear applies, start_stop ignored.
  - RUN, tick and start_stop in the same cycle: tick counted, PAUSE from next cycle.
  - PAUSE, tick and start_stop in the same cycle: tick not counted.
- Reset mid-count: next cycle all zero and IDLE regardless of state.

Optional Feature:
- Macro LAP_HOLD_EN.
- Defined:
  - In RUN, a lap edge latches the current digits into hold registers, sets lap_held, and outputs show the held value while the internal count continues.
  - A second lap edge, a clear edge, or a transition to PAUSE releases the hold: lap_held goes to 0 and outputs show the live count the same cycle.
  - A lap edge outside RUN is ignored.
- Not defined: lap ignored, lap_held tied 0, outputs always live, no hold registers.

Test Plan:
- Reset, then start_stop pulse, bench toggles centisecond_clock every 8 clk for 100 rising edges -> 00:01.00, running=1.
- Preload by running 5999 ticks from 00:00.00 -> 00:59.99; one more tick -> 01:00.00, sec_tens never exceeds 5.
- MIN_LIMIT=1: run to 01:59.99, one tick -> 00:00.00, overflow=1; clear edge -> overflow=0, count 0.
- Run to 00:00.37, start_stop (PAUSE), 20 ticks -> still 00:00.37; start_stop -> resumes, 3 ticks -> 00:00.40.
- Tick edge and clear edge in same clk cycle while at 00:00.05 -> 00:00.00; hold centisecond_clock high 50 clk -> exactly one increment.
- LAP_HOLD_EN: lap at 00:00.10, 25 more ticks -> outputs show 00:00.10, lap_held=1; lap again -> outputs 00:00.35, lap_held=0.

Source files
------------

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD stopwatch MM:SS.CC with start/stop/clear control.
//
// centisecond_clock is sampled as data. It is synchronized, and each rising
// edge gives one count. The buttons start_stop, clear and lap are levels. They
// pass through the same synchronizer and edge-detect pipeline as the
// centisecond input. Because the pipeline depth is the same for all of them,
// inputs that change on the same clk cycle are also seen on the same cycle
// inside the block.
//
// Optional feature: define LAP_HOLD_EN to enable lap hold. A lap edge in RUN
// freezes the displayed digits while the count keeps running.
//
// Parameters:
//   MIN_LIMIT   highest minute value (1..99) before wrapping to 00:00.00
//   SYNC_STAGES synchronizer flops ahead of the edge detect (>= 2)
//
// Ports:
//   clk, reset          system clock; synchronous active-high reset
//   centisecond_clock   divider output, one rising edge = one centisecond
//   start_stop          rising edge toggles run/pause
//   clear               rising edge zeroes the count and overflow
//   lap                 rising edge toggles display hold (LAP_HOLD_EN only)
//   cs_*, sec_*, min_*  BCD digits to the display mux
//   running             high in RUN
//   overflow            sticky; set on a MIN_LIMIT:59.99 -> 00:00.00 wrap
//   lap_held            display frozen (constant 0 without LAP_HOLD_EN)
module stopwatch_counter #(
  parameter int MIN_LIMIT   = 99,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       centisecond_clock,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cs_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       overflow,
  output logic       lap_held
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] cs_tens;
    logic [3:0] cs_ones;
  } time_t;

  localparam logic [3:0] LIM_TENS = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] LIM_ONES = 4'(MIN_LIMIT % 10);

  // Synchronizer and edge detect.
  // Bit 0 = centisecond, 1 = start_stop, 2 = clear, 3 = lap.
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  dly_q;
  logic [3:0]                  rise;
  logic                        tick, ss_e, clr_e, lap_e;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {lap, clear, start_stop, centisecond_clock}};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign tick  = rise[0];
  assign ss_e  = rise[1];
  assign clr_e = rise[2];
  assign lap_e = rise[3];

  // FSM
  state_t state_q, state_d;
  logic   do_clr, do_inc;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A clear edge always wins over start_stop and over a tick in the same cycle.
  always_comb begin
    state_d = state_q;
    do_clr  = 1'b0;
    do_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clr_e)     do_clr  = 1'b1;
        else if (ss_e) state_d = RUN;
      end
      RUN: begin
        if (clr_e) do_clr = 1'b1;
        else begin
          do_inc = tick;               // the tick still counts on the pause edge
          if (ss_e) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (clr_e) begin
          do_clr  = 1'b1;
          state_d = IDLE;
        end else if (ss_e) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // BCD increment chain
  time_t cnt_q, inc;
  logic  wrap;
  logic  ovf_q;

  always_comb begin
    inc  = cnt_q;
    wrap = 1'b0;
    if (cnt_q.cs_ones != 4'd9) inc.cs_ones = cnt_q.cs_ones + 4'd1;
    else begin
      inc.cs_ones = 4'd0;
      if (cnt_q.cs_tens != 4'd9) inc.cs_tens = cnt_q.cs_tens + 4'd1;
      else begin
        inc.cs_tens = 4'd0;
        if (cnt_q.sec_ones != 4'd9) inc.sec_ones = cnt_q.sec_ones + 4'd1;
        else begin
          inc.sec_ones = 4'd0;
          if (cnt_q.sec_tens != 4'd5) inc.sec_tens = cnt_q.sec_tens + 4'd1;
          else begin
            inc.sec_tens = 4'd0;
            if (cnt_q.min_tens == LIM_TENS && cnt_q.min_ones == LIM_ONES) begin
              inc  = '0;
              wrap = 1'b1;
            end else if (cnt_q.min_ones == 4'd9) begin
              inc.min_ones = 4'd0;
              inc.min_tens = cnt_q.min_tens + 4'd1;
            end else begin
              inc.min_ones = cnt_q.min_ones + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || do_clr) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (do_inc) begin
      cnt_q <= inc;
      if (wrap) ovf_q <= 1'b1;
    end
  end

  assign running  = (state_q == RUN);
  assign overflow = ovf_q;

  // Display path
  time_t disp;

`ifdef LAP_HOLD_EN
  time_t hold_q;
  logic  held_q;
  logic  to_pause;

  assign to_pause = (state_q == RUN) && (state_d == PAUSE);

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q <= 1'b0;
      hold_q <= '0;
    end else if (clr_e || to_pause) begin
      held_q <= 1'b0;
    end else if (state_q == RUN && lap_e) begin
      if (held_q) held_q <= 1'b0;
      else begin
        held_q <= 1'b1;
        hold_q <= cnt_q;
      end
    end
  end

  assign disp     = held_q ? hold_q : cnt_q;
  assign lap_held = held_q;
`else
  logic unused_lap;
  assign unused_lap = lap_e;
  assign disp       = cnt_q;
  assign lap_held   = 1'b0;
`endif

  assign {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones} = disp;

endmodule
